// File: rtl/asic_if_pkg.sv
// Shared definitions for the multi-channel ASIC function register interface.
// Holds the per-channel register offsets, the INFO register address and ID,
// the AXI response codes, the write-channel FSM states and the address
// decode helper. The top level and the channel register block import it.
package asic_if_pkg;

  // Byte offsets inside a 16-byte channel window.
  localparam logic [3:0] CTRL_OFF = 4'h0;
  localparam logic [3:0] DOUT_OFF = 4'h4;
  localparam logic [3:0] DIN_OFF  = 4'h8;
  localparam logic [3:0] STAT_OFF = 4'hC;

  localparam logic [8:0]  INFO_ADDR = 9'h100;
  localparam logic [15:0] INFO_ID   = 16'h0A51;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_COMMIT,
    W_RESP
  } wr_state_e;

  // Word address ADDR[8:2] -> 1 if it hits INFO or an existing channel.
  function automatic logic addr_mapped(input logic [8:2] a, input int nc);
    if (a[8]) return (a == INFO_ADDR[8:2]);
    return (int'(a[7:4]) < nc);
  endfunction

endpackage

// File: rtl/asic_channel_regs.sv
// One ASIC function channel: CTRL (mode + write-1 start), DATA_OUT,
// DATA_IN (captured on asic_done) and STATUS (busy, sticky W1C done).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   wr_en, wr_off     commit strobe and byte offset of the committed write
//   wdata, wstrb      committed write data and byte strobes
//   rd_off, rd_data   combinational read of the register at rd_off
//   asic_start        one-cycle start pulse, the cycle after the commit
//   asic_mode         CTRL[31:1]
//   asic_data_out     DATA_OUT register
//   asic_data_in      result data, captured when asic_done is high
//   asic_done         one-cycle completion pulse
module asic_channel_regs
  import asic_if_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [3:0]    wr_off,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wstrb,
  input  logic [3:0]    rd_off,
  output logic [31:0]   rd_data,
  output logic          asic_start,
  output logic [30:0]   asic_mode,
  output logic [DW-1:0] asic_data_out,
  input  logic [DW-1:0] asic_data_in,
  input  logic          asic_done
);

  logic [30:0]   mode_q, mode_d;
  logic [DW-1:0] dout_q, dout_d;
  logic [DW-1:0] din_q, din_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          start_q, start_d;
  logic [31:0]   be_mask;

  always_comb begin
    be_mask = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
    mode_d  = mode_q;
    dout_d  = dout_q;
    din_d   = din_q;
    busy_d  = busy_q;
    done_d  = done_q;
    start_d = 1'b0;
    if (wr_en) begin
      case (wr_off)
        CTRL_OFF: begin
          mode_d = (mode_q & ~be_mask[31:1]) | (wdata[31:1] & be_mask[31:1]);
          // A start request while a run is in progress is dropped silently.
          start_d = wdata[0] && wstrb[0] && !busy_q;
        end
        DOUT_OFF: dout_d = (dout_q & ~be_mask[DW-1:0]) | (wdata[DW-1:0] & be_mask[DW-1:0]);
        STAT_OFF: if (wdata[1] && wstrb[0]) done_d = 1'b0;
        default: ;
      endcase
    end
    // Completion is applied after the W1C so that a same-cycle set wins.
    if (asic_done) begin
      busy_d = 1'b0;
      done_d = 1'b1;
      din_d  = asic_data_in;
    end
    // A same-cycle accepted start keeps the channel busy.
    if (start_d) busy_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= '0;
      dout_q  <= '0;
      din_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      dout_q  <= dout_d;
      din_q   <= din_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      start_q <= start_d;
    end
  end

  always_comb begin
    rd_data = '0;
    case (rd_off)
      CTRL_OFF: rd_data = {mode_q, 1'b0};
      DOUT_OFF: rd_data[DW-1:0] = dout_q;
      DIN_OFF:  rd_data[DW-1:0] = din_q;
      STAT_OFF: rd_data[1:0] = {done_q, busy_q};
      default:  rd_data = '0;
    endcase
  end

  assign asic_start    = start_q;
  assign asic_mode     = mode_q;
  assign asic_data_out = dout_q;

endmodule

// File: rtl/asic_function_interface_axi_regs_mc.sv
// AXI4-Lite slave register file fronting NUM_CHANNELS ASIC function
// channels, each at byte base c*0x10, plus a read-only INFO word at 0x100.
// Ports: S_AXI_* is the AXI4-Lite slave (clock, active-low async reset,
// AW/W/B write channels, AR/R read channels); asic_* are the per-channel
// start pulse, mode, data out, data in and done pulse, channel c in slice c.
// Handshake: every channel transfers on a cycle where VALID and READY are
// both high at the rising clock edge; a source holds VALID and its payload
// stable until that edge, and the slave holds BVALID/BRESP and
// RVALID/RDATA/RRESP stable until BREADY/RREADY is seen.
module asic_function_interface_axi_regs_mc
  import asic_if_pkg::*;
#(
  parameter int C_S_AXI_ACLK_FREQ_HZ = 100000000,
  parameter int C_S_AXI_DATA_WIDTH   = 32,
  parameter int C_S_AXI_ADDR_WIDTH   = 9,
  parameter int NUM_CHANNELS         = 4,
  parameter int ASIC_DATA_WIDTH      = 32
) (
  input  logic                                    S_AXI_ACLK,
  input  logic                                    S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]           S_AXI_AWADDR,
  input  logic                                    S_AXI_AWVALID,
  output logic                                    S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]           S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]         S_AXI_WSTRB,
  input  logic                                    S_AXI_WVALID,
  output logic                                    S_AXI_WREADY,
  output logic [1:0]                              S_AXI_BRESP,
  output logic                                    S_AXI_BVALID,
  input  logic                                    S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]           S_AXI_ARADDR,
  input  logic                                    S_AXI_ARVALID,
  output logic                                    S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]           S_AXI_RDATA,
  output logic [1:0]                              S_AXI_RRESP,
  output logic                                    S_AXI_RVALID,
  input  logic                                    S_AXI_RREADY,
  output logic [NUM_CHANNELS-1:0]                 asic_start,
  output logic [NUM_CHANNELS*31-1:0]              asic_mode,
  output logic [NUM_CHANNELS*ASIC_DATA_WIDTH-1:0] asic_data_out,
  input  logic [NUM_CHANNELS*ASIC_DATA_WIDTH-1:0] asic_data_in,
  input  logic [NUM_CHANNELS-1:0]                 asic_done
);

  wr_state_e         state_q, state_d;
  logic [8:2]        awaddr_q, awaddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic              aw_fire, w_fire, ar_fire, commit;
  logic [31:0]       rd_val;
  logic [31:0]       ch_rdata [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] ch_wr_en;

  // ---------------- write FSM: state register ----------------
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) state_q <= W_IDLE;
    else                state_q <= state_d;
  end

  // ---------------- write FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      W_IDLE, W_RESP: begin
        // Leaving W_RESP needs BREADY; the READYs reopen in that same cycle.
        if (state_q == W_IDLE || S_AXI_BREADY) begin
          if (aw_fire && w_fire) state_d = W_COMMIT;
          else if (aw_fire)      state_d = W_HAVE_AW;
          else if (w_fire)       state_d = W_HAVE_W;
          else                   state_d = W_IDLE;
        end
      end
      W_HAVE_AW: if (w_fire)  state_d = W_COMMIT;
      W_HAVE_W:  if (aw_fire) state_d = W_COMMIT;
      W_COMMIT:  state_d = W_RESP;
      default:   state_d = W_IDLE;
    endcase
  end

  // ---------------- write FSM: outputs ----------------
  always_comb begin
    S_AXI_AWREADY = (state_q == W_IDLE) || (state_q == W_HAVE_W) ||
                    ((state_q == W_RESP) && S_AXI_BREADY);
    S_AXI_WREADY  = (state_q == W_IDLE) || (state_q == W_HAVE_AW) ||
                    ((state_q == W_RESP) && S_AXI_BREADY);
    S_AXI_BVALID  = (state_q == W_RESP);
    commit        = (state_q == W_COMMIT);
  end

  assign aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_fire  = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_fire = S_AXI_ARVALID && !rvalid_q;

  // ---------------- address decode and read mux ----------------
  always_comb begin
    rd_val = '0;
    if (S_AXI_ARADDR[8]) begin
      if (S_AXI_ARADDR[8:2] == INFO_ADDR[8:2])
        rd_val = {INFO_ID, 8'd0, 8'(NUM_CHANNELS)};
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++)
        if (S_AXI_ARADDR[7:4] == 4'(c)) rd_val = ch_rdata[c];
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++)
      ch_wr_en[c] = commit && !awaddr_q[8] && (awaddr_q[7:4] == 4'(c));
  end

  // ---------------- AXI datapath ----------------
  always_comb begin
    awaddr_d = aw_fire ? S_AXI_AWADDR[8:2] : awaddr_q;
    wdata_d  = w_fire  ? S_AXI_WDATA : wdata_q;
    wstrb_d  = w_fire  ? S_AXI_WSTRB : wstrb_q;
    bresp_d  = bresp_q;
    if (commit) bresp_d = addr_mapped(awaddr_q, NUM_CHANNELS) ? RESP_OKAY : RESP_SLVERR;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rvalid_q && S_AXI_RREADY) rvalid_d = 1'b0;
    // Captured from the current flop values, so a same-cycle write is not seen.
    if (ar_fire) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_val;
      rresp_d  = addr_mapped(S_AXI_ARADDR[8:2], NUM_CHANNELS) ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      awaddr_q <= awaddr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      bresp_q  <= bresp_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = !rvalid_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

  // ---------------- channels ----------------
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    asic_channel_regs #(.DW(ASIC_DATA_WIDTH)) u_ch (
      .clk           (S_AXI_ACLK),
      .rst_n         (S_AXI_ARESETN),
      .wr_en         (ch_wr_en[c]),
      .wr_off        ({awaddr_q[3:2], 2'b00}),
      .wdata         (wdata_q),
      .wstrb         (wstrb_q),
      .rd_off        ({S_AXI_ARADDR[3:2], 2'b00}),
      .rd_data       (ch_rdata[c]),
      .asic_start    (asic_start[c]),
      .asic_mode     (asic_mode[c*31 +: 31]),
      .asic_data_out (asic_data_out[c*ASIC_DATA_WIDTH +: ASIC_DATA_WIDTH]),
      .asic_data_in  (asic_data_in[c*ASIC_DATA_WIDTH +: ASIC_DATA_WIDTH]),
      .asic_done     (asic_done[c])
    );
  end

  // Address bits outside [8:2] and the clock-frequency parameter carry no logic.
  logic unused_ok;
  assign unused_ok = &{1'b0, S_AXI_AWADDR, S_AXI_ARADDR, (C_S_AXI_ACLK_FREQ_HZ != 0)};

endmodule

// File: tb/tb_asic_function_interface_axi_regs_mc.sv
module tb_asic_function_interface_axi_regs_mc;

  localparam int NC = 4;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [8:0]     S_AXI_AWADDR, S_AXI_ARADDR;
  logic           S_AXI_AWVALID, S_AXI_AWREADY;
  logic [31:0]    S_AXI_WDATA;
  logic [3:0]     S_AXI_WSTRB;
  logic           S_AXI_WVALID, S_AXI_WREADY;
  logic [1:0]     S_AXI_BRESP;
  logic           S_AXI_BVALID, S_AXI_BREADY;
  logic           S_AXI_ARVALID, S_AXI_ARREADY;
  logic [31:0]    S_AXI_RDATA;
  logic [1:0]     S_AXI_RRESP;
  logic           S_AXI_RVALID, S_AXI_RREADY;
  logic [NC-1:0]      asic_start;
  logic [NC*31-1:0]   asic_mode;
  logic [NC*DW-1:0]   asic_data_out;
  logic [NC*DW-1:0]   asic_data_in;
  logic [NC-1:0]      asic_done;

  asic_function_interface_axi_regs_mc #(
    .C_S_AXI_ACLK_FREQ_HZ(100000000), .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(9), .NUM_CHANNELS(NC), .ASIC_DATA_WIDTH(DW)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .asic_start(asic_start), .asic_mode(asic_mode), .asic_data_out(asic_data_out),
    .asic_data_in(asic_data_in), .asic_done(asic_done)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [33:0] exp_q[$];   // {rresp, rdata}
  logic [1:0]  bexp_q[$];
  logic [31:0] dout_m [NC];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Start pulse monitor: counts pulses and flags any pulse longer than one cycle.
  int start_cnt [NC] = '{default: 0};
  int dbl_pulse = 0;
  logic [NC-1:0] prev_start = '0;
  always @(negedge clk) begin
    for (int c = 0; c < NC; c++) if (asic_start[c] === 1'b1) start_cnt[c]++;
    if (|(asic_start & prev_start)) dbl_pulse++;
    prev_start = asic_start;
  end

  // ---------------- driver tasks ----------------
  task automatic axi_write(input logic [8:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic [1:0] resp, input int aw_delay, input int b_delay);
    bit aw_done, w_done, aw_f, w_f, got_b;
    int n_wait;
    logic [1:0] r;
    bexp_q.push_back(resp);
    @(negedge clk);
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
    aw_done = 0; w_done = 0;
    for (int n = 0; n < 40 && !(aw_done && w_done); n++) begin
      if (!aw_done && n >= aw_delay) S_AXI_AWVALID = 1'b1;
      aw_f = S_AXI_AWVALID && S_AXI_AWREADY;
      w_f  = S_AXI_WVALID && S_AXI_WREADY;
      @(posedge clk); #1;
      if (aw_f) begin aw_done = 1; S_AXI_AWVALID = 1'b0; end
      if (w_f)  begin w_done = 1;  S_AXI_WVALID = 1'b0; end
    end
    check("aw_accept", 64'(aw_done), 64'd1);
    check("w_accept", 64'(w_done), 64'd1);
    got_b = 0; n_wait = 0;
    for (int n = 0; n < 20 && !got_b; n++) begin
      if (S_AXI_BVALID) got_b = 1;
      else begin @(posedge clk); #1; n_wait++; end
    end
    check("bvalid_seen", 64'(got_b), 64'd1);
    check("b_latency", 64'(n_wait), 64'd1);
    if (got_b) begin
      for (int k = 0; k < b_delay; k++) begin
        @(posedge clk); #1;
        check("b_hold", 64'(S_AXI_BVALID), 64'd1);
        check("aw_blocked", 64'(S_AXI_AWREADY), 64'd0);
      end
      S_AXI_BREADY = 1'b1;
      r = bexp_q.pop_front();
      check("bresp", 64'(S_AXI_BRESP), 64'(r));
      @(posedge clk); #1;
      S_AXI_BREADY = 1'b0;
      check("b_drop", 64'(S_AXI_BVALID), 64'd0);
    end
  endtask

  task automatic axi_read(input string tag, input logic [8:0] addr,
                          input logic [31:0] data, input logic [1:0] resp);
    bit done, fire, got;
    logic [33:0] e;
    exp_q.push_back({resp, data});
    @(negedge clk);
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
    done = 0;
    for (int n = 0; n < 20 && !done; n++) begin
      fire = S_AXI_ARVALID && S_AXI_ARREADY;
      @(posedge clk); #1;
      if (fire) begin done = 1; S_AXI_ARVALID = 1'b0; end
    end
    check("ar_accept", 64'(done), 64'd1);
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      if (S_AXI_RVALID) got = 1;
      else begin @(posedge clk); #1; end
    end
    check("rvalid_seen", 64'(got), 64'd1);
    if (got) begin
      e = exp_q.pop_front();
      check(tag, 64'({S_AXI_RRESP, S_AXI_RDATA}), 64'(e));
      S_AXI_RREADY = 1'b1;
      @(posedge clk); #1;
      S_AXI_RREADY = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d;
    logic [3:0]  s;
    int c;
    logic [31:0] m;

    rst_n = 1'b0;
    S_AXI_AWADDR = '0; S_AXI_AWVALID = 0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0;
    S_AXI_WVALID = 0; S_AXI_BREADY = 0; S_AXI_ARADDR = '0; S_AXI_ARVALID = 0;
    S_AXI_RREADY = 0; asic_data_in = '0; asic_done = '0;
    for (int i = 0; i < NC; i++) dout_m[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", 64'(S_AXI_AWREADY), 64'd1);
    check("rst_wready", 64'(S_AXI_WREADY), 64'd1);
    check("rst_arready", 64'(S_AXI_ARREADY), 64'd1);
    check("rst_bvalid", 64'(S_AXI_BVALID), 64'd0);
    check("rst_rvalid", 64'(S_AXI_RVALID), 64'd0);
    check("rst_rdata", 64'(S_AXI_RDATA), 64'd0);
    check("rst_start", 64'(asic_start), 64'd0);
    check("rst_mode_zero", 64'(asic_mode == '0), 64'd1);
    check("rst_dout_zero", 64'(asic_data_out == '0), 64'd1);
    rst_n = 1'b1;

    // INFO and all channel registers after reset
    axi_read("info", 9'h100, 32'h0A510004, 2'b00);
    for (int a = 0; a < NC * 16; a += 4) axi_read("rst_reg", 9'(a), 32'h0, 2'b00);

    // Byte strobes on DATA_OUT ch2
    axi_write(9'h024, 32'h11223344, 4'b1111, 2'b00, 0, 0);
    axi_write(9'h024, 32'hDEADBEEF, 4'b0011, 2'b00, 0, 0);
    dout_m[2] = 32'h1122BEEF;
    check("dout_ch2_strb", 64'(asic_data_out[2*DW +: DW]), 64'h1122BEEF);
    axi_read("dout_ch2_rd", 9'h024, 32'h1122BEEF, 2'b00);
    axi_read("addr_lsb_ignored", 9'h027, 32'h1122BEEF, 2'b00);

    // Start ch1, then a second start while busy
    axi_write(9'h010, 32'h00000007, 4'b1111, 2'b00, 0, 0);
    check("start_ch1_once", 64'(start_cnt[1]), 64'd1);
    check("mode_ch1", 64'(asic_mode[1*31 +: 31]), 64'd3);
    axi_read("ctrl_ch1_rd", 9'h010, 32'h00000006, 2'b00);
    axi_read("stat_busy", 9'h01C, 32'h1, 2'b00);
    axi_write(9'h010, 32'h00000007, 4'b1111, 2'b00, 0, 0);
    check("start_while_busy", 64'(start_cnt[1]), 64'd1);
    axi_read("stat_still_busy", 9'h01C, 32'h1, 2'b00);

    // Completion on ch1, then W1C of done
    @(negedge clk);
    asic_data_in[1*DW +: DW] = 32'hCAFE0001;
    asic_done = 4'b0010;
    @(negedge clk);
    asic_done = '0;
    asic_data_in = '0;
    axi_read("din_ch1", 9'h018, 32'hCAFE0001, 2'b00);
    axi_read("stat_done", 9'h01C, 32'h2, 2'b00);
    axi_write(9'h01C, 32'h2, 4'b0001, 2'b00, 0, 0);
    axi_read("stat_cleared", 9'h01C, 32'h0, 2'b00);

    // W three cycles ahead of AW, BREADY held off five cycles
    d = $urandom;
    axi_write(9'h034, d, 4'b1111, 2'b00, 3, 5);
    dout_m[3] = d;
    check("dout_ch3_late_aw", 64'(asic_data_out[3*DW +: DW]), 64'(d));
    check("no_extra_start", 64'(start_cnt[3]), 64'd0);

    // Unmapped and read-only accesses
    axi_read("unmapped_rd", 9'h040, 32'h0, 2'b10);
    axi_read("unmapped_hi_rd", 9'h104, 32'h0, 2'b10);
    axi_write(9'h1F0, 32'hFFFFFFFF, 4'b1111, 2'b10, 0, 0);
    axi_write(9'h044, 32'hFFFFFFFF, 4'b1111, 2'b10, 0, 0);
    axi_write(9'h018, 32'h12345678, 4'b1111, 2'b00, 0, 0);
    axi_read("din_ro_kept", 9'h018, 32'hCAFE0001, 2'b00);
    for (int i = 0; i < NC; i++)
      check("dout_unchanged", 64'(asic_data_out[i*DW +: DW]), 64'(dout_m[i]));

    // Random strobed DATA_OUT writes against a byte-merge model
    for (int i = 0; i < 6; i++) begin
      c = $urandom_range(0, NC - 1);
      d = $urandom;
      s = 4'($urandom_range(1, 15));
      axi_write(9'(c * 16 + 4), d, s, 2'b00, $urandom_range(0, 2), $urandom_range(0, 2));
      m = dout_m[c];
      for (int b = 0; b < 4; b++) if (s[b]) m[b*8 +: 8] = d[b*8 +: 8];
      dout_m[c] = m;
      check("dout_rand", 64'(asic_data_out[c*DW +: DW]), 64'(m));
      axi_read("dout_rand_rd", 9'(c * 16 + 4), m, 2'b00);
    end

    // Reset in the commit cycle of a start write on ch0
    @(negedge clk);
    S_AXI_AWADDR = 9'h000; S_AXI_WDATA = 32'h1; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    @(posedge clk); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_mid_bvalid", 64'(S_AXI_BVALID), 64'd0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_mid_no_start", 64'(start_cnt[0]), 64'd0);
    check("rst_mid_awready", 64'(S_AXI_AWREADY), 64'd1);
    axi_read("rst_mid_stat", 9'h00C, 32'h0, 2'b00);
    axi_read("rst_mid_dout", 9'h024, 32'h0, 2'b00);

    check("single_cycle_pulses", 64'(dbl_pulse), 64'd0);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("bexp_q_drained", 64'(bexp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
